// File: rtl/s_mod_reduce.sv
// rtl/s_mod_reduce.sv - restoring shift-subtract reducer R = {Hreg,Lreg} mod N, one product bit per clock
// Optional quotient output Q is built when SMOD_QUOTIENT_EN is defined.
module s_mod_reduce #(
    parameter int BIT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [BIT:0]   Hreg,
    input  logic [BIT-1:0] Lreg,
    input  logic [BIT-1:0] N,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [BIT-1:0] R
`ifdef SMOD_QUOTIENT_EN
    ,
    output logic [2*BIT:0] Q
`endif
);

    localparam int PW = 2 * BIT + 1;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  p_q, p_d;
    logic [BIT-1:0] n_q, n_d;
    logic [BIT-1:0] rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BIT-1:0] r_q, r_d;
    logic           err_q, err_d;
`ifdef SMOD_QUOTIENT_EN
    logic [PW-1:0]  quo_q, quo_d;
`endif

    // rem < N holds after every step, so the stored remainder needs only BIT bits;
    // the shifted trial value t carries the extra bit.
    logic [BIT:0]   t;
    logic           ge;
    logic [BIT-1:0] diff;
    logic           n_zero;

    assign t      = {rem_q, p_q[PW-1]};
    assign ge     = (t >= {1'b0, n_q});
    assign diff   = t[BIT-1:0] - n_q;
    assign n_zero = (n_q == '0);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        n_d     = n_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        err_d   = err_q;
`ifdef SMOD_QUOTIENT_EN
        quo_d   = quo_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = {Hreg, Lreg};
                    n_d     = N;
                    rem_d   = '0;
                    r_d     = '0;
                    err_d   = 1'b0;
`ifdef SMOD_QUOTIENT_EN
                    quo_d   = '0;
`endif
                    // A zero modulus spends one idle busy cycle so done timing stays uniform.
                    cnt_d   = (N == '0) ? CW'(1) : CW'(PW);
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (!n_zero) begin
                    rem_d = ge ? diff : t[BIT-1:0];
                    p_d   = {p_q[PW-2:0], 1'b0};
`ifdef SMOD_QUOTIENT_EN
                    quo_d = {quo_q[PW-2:0], ge};
`endif
                end
                if (cnt_q == CW'(1)) begin
                    err_d   = n_zero;
                    r_d     = n_zero ? '0 : (ge ? diff : t[BIT-1:0]);
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            n_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
`ifdef SMOD_QUOTIENT_EN
            quo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            err_q   <= err_d;
`ifdef SMOD_QUOTIENT_EN
            quo_q   <= quo_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == FIN);
    assign R    = r_q;
    assign err  = err_q;
`ifdef SMOD_QUOTIENT_EN
    assign Q    = quo_q;
`endif

endmodule

// File: tb/tb_s_mod_reduce.sv
// tb/tb_s_mod_reduce.sv - randomized self-checking bench for s_mod_reduce against an arithmetic model
module tb_s_mod_reduce;

    localparam int BIT = 8;
    localparam int PW  = 2 * BIT + 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [BIT:0]   Hreg;
    logic [BIT-1:0] Lreg;
    logic [BIT-1:0] N;
    logic           busy;
    logic           done;
    logic           err;
    logic [BIT-1:0] R;
`ifdef SMOD_QUOTIENT_EN
    logic [PW-1:0]  Q;
`endif

    s_mod_reduce #(.BIT(BIT)) dut (
`ifdef SMOD_QUOTIENT_EN
        .Q     (Q),
`endif
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .Hreg  (Hreg),
        .Lreg  (Lreg),
        .N     (N),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .R     (R)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Hand-computed pins attached to the next accepted request.
    logic           pin_v = 1'b0;
    logic [BIT-1:0] pin_r = '0;
    logic [PW-1:0]  pin_q = '0;

    // Behavioural model: remaining busy cycles, then a done cycle carrying P mod N.
    int             m_left  = 0;
    logic           m_done  = 1'b0;
    logic [BIT-1:0] m_r     = '0;
    logic           m_err   = 1'b0;
    logic [PW-1:0]  m_q     = '0;
    logic [PW-1:0]  m_p     = '0;
    logic [BIT-1:0] m_n     = '0;
    logic           m_pin_v = 1'b0;
    logic [BIT-1:0] m_pin_r = '0;
    logic [PW-1:0]  m_pin_q = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_r     <= '0;
            m_err   <= 1'b0;
            m_q     <= '0;
            m_pin_v <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                if (m_n == 0) begin
                    m_r   <= '0;
                    m_q   <= '0;
                    m_err <= 1'b1;
                end else begin
                    m_r   <= BIT'(m_p % m_n);
                    m_q   <= m_p / m_n;
                    m_err <= 1'b0;
                end
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_p     <= {Hreg, Lreg};
            m_n     <= N;
            m_left  <= (N == 0) ? 1 : PW;
            m_r     <= '0;
            m_q     <= '0;
            m_err   <= 1'b0;
            m_pin_v <= pin_v;
            m_pin_r <= pin_r;
            m_pin_q <= pin_q;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_err",  32'(err),  32'd0);
            chk("rst_r",    32'(R),    32'd0);
`ifdef SMOD_QUOTIENT_EN
            chk("rst_q",    32'(Q),    32'd0);
`endif
        end else begin
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("err",  32'(err),  32'(m_err));
            if (m_left == 0) begin
                chk("r", 32'(R), 32'(m_r));
`ifdef SMOD_QUOTIENT_EN
                chk("q", 32'(Q), 32'(m_q));
`endif
            end
            if (m_done && m_pin_v) begin
                chk("pin_r", 32'(R), 32'(m_pin_r));
`ifdef SMOD_QUOTIENT_EN
                chk("pin_q", 32'(Q), 32'(m_pin_q));
`endif
            end
        end
    end

    task automatic do_op(input logic [BIT:0] h, input logic [BIT-1:0] l, input logic [BIT-1:0] n,
                         input logic [BIT-1:0] pr, input logic [PW-1:0] pq);
        @(negedge clk);
        Hreg = h; Lreg = l; N = n;
        pin_v = 1'b1; pin_r = pr; pin_q = pq;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pin_v = 1'b0;
        Hreg = 9'($urandom); Lreg = 8'($urandom); N = 8'($urandom);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        Hreg = '0; Lreg = '0; N = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_op(9'h100, 8'h00, 8'hFF, 8'h01, 17'h101);
        do_op(9'h000, 8'h05, 8'h09, 8'h05, 17'h000);
        do_op(9'h123, 8'h45, 8'h01, 8'h00, 17'h12345);
        do_op(9'h1A5, 8'h5A, 8'h00, 8'h00, 17'h000);
        do_op(9'h0FE, 8'h01, 8'hFB, 8'h10, 17'h103);

        // Stray start mid-operation, then start held high across consecutive operations.
        @(negedge clk);
        Hreg = 9'h000; Lreg = 8'h22; N = 8'h07;
        pin_v = 1'b1; pin_r = 8'h06; pin_q = 17'h004;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        Hreg = 9'h1FF; Lreg = 8'hFF; N = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        Hreg = 9'h0FE; Lreg = 8'h01; N = 8'hFB;
        pin_r = 8'h10; pin_q = 17'h103;
        start = 1'b1;
        repeat (45) @(negedge clk);
        start = 1'b0;
        pin_v = 1'b0;
        repeat (25) @(negedge clk);

        // Reset in the middle of an operation, then rerun the same operands.
        @(negedge clk);
        Hreg = 9'h0FE; Lreg = 8'h01; N = 8'hFB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        do_op(9'h0FE, 8'h01, 8'hFB, 8'h10, 17'h103);

        for (int i = 0; i < 40; i++) begin
            int k;
            int sel;
            sel = int'($urandom_range(0, 9));
            @(negedge clk);
            Hreg = 9'($urandom);
            Lreg = 8'($urandom);
            N = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : (sel == 2) ? 8'hFF : 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = int'($urandom_range(1, 15));
            repeat (k) @(negedge clk);
            Hreg = 9'($urandom); Lreg = 8'($urandom); N = 8'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (20 - k) @(negedge clk);
        end
        repeat (25) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
